// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared definitions for the bin2bcd converter arbiter.
// State encoding, BCD slot width and owner index width.
package bcd_conv_arbiter_pkg;

  localparam int OWN_W = 2;
  localparam int BCD_W = 24;
  localparam logic [BCD_W-1:0] BCD_SAT = 24'h999999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// Round-robin pick: first asserted request after the
// last served index, wrapping modulo NREQ.
module rr_pick
  import bcd_conv_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [OWN_W-1:0] last,
  output logic             any,
  output logic [OWN_W-1:0] winner
);

  logic found;

  assign any = |req;

  // scan last+1, last+2, ... so the last winner ranks lowest
  always_comb begin
    winner = last;
    found  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[(int'(last) + i) % NREQ]) begin
        winner = OWN_W'((int'(last) + i) % NREQ);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one bin2bcd converter between NREQ requesters,
// with per-requester result slots and a done watchdog.
module bcd_conv_arbiter
  import bcd_conv_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int BIN_W   = 21,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*BIN_W-1:0] bin_in,
  output logic [NREQ-1:0]       done_out,
  output logic [NREQ*BCD_W-1:0] dig_out,
  output logic                  busy,
  output logic [OWN_W-1:0]      owner,
  output logic                  timeout_err,
  output logic                  conv_start,
  output logic [BIN_W-1:0]      conv_bin,
  input  logic                  conv_ready,
  input  logic                  conv_done,
  input  logic [BCD_W-1:0]      conv_dig
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  state_t             state;
  logic [OWN_W-1:0]   last;
  logic [WD_W-1:0]    wd;
  logic [BCD_W-1:0]   slot [NREQ];
  logic               any;
  logic [OWN_W-1:0]   winner;
  logic [BIN_W-1:0]   bin_sel;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .last   (last),
    .any    (any),
    .winner (winner)
  );

  // operand of the current round-robin winner
  always_comb begin
    bin_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (winner == OWN_W'(k)) bin_sel = bin_in[k*BIN_W +: BIN_W];
    end
  end

  assign busy        = (state != IDLE);
  assign conv_start  = (state == ISSUE) && conv_ready;
  assign timeout_err = (state == WAIT) && !conv_done && (wd == WD_MAX);

  for (genvar k = 0; k < NREQ; k++) begin : g_slot
    assign dig_out[k*BCD_W +: BCD_W] = slot[k];
    assign done_out[k] = (state == DONE) && (owner == OWN_W'(k));
  end

  // grant, converter handshake, watchdog and slot update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      last     <= OWN_W'(NREQ - 1);
      conv_bin <= '0;
      wd       <= '0;
      for (int k = 0; k < NREQ; k++) slot[k] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            owner    <= winner;
            conv_bin <= bin_sel;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (conv_ready) begin
            wd    <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          wd <= wd + WD_W'(1);
          if (conv_done) begin
            for (int k = 0; k < NREQ; k++)
              if (owner == OWN_W'(k)) slot[k] <= conv_dig;
            state <= DONE;
          end else if (wd == WD_MAX) begin
            for (int k = 0; k < NREQ; k++)
              if (owner == OWN_W'(k)) slot[k] <= BCD_SAT;
            state <= DONE;
          end
        end
        DONE: begin
          last  <= owner;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a
// behavioural bin2bcd converter driven from tasks.
module tb_bcd_conv_arbiter;

  localparam int NREQ  = 2;
  localparam int BIN_W = 21;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*BIN_W-1:0] bin_in;
  logic [NREQ-1:0]       done_out;
  logic [NREQ*24-1:0]    dig_out;
  logic                  busy;
  logic [1:0]            owner;
  logic                  timeout_err;
  logic                  conv_start;
  logic [BIN_W-1:0]      conv_bin;
  logic                  conv_ready;
  logic                  conv_done;
  logic [23:0]           conv_dig;

  int n_chk  = 0;
  int n_fail = 0;

  bcd_conv_arbiter #(.NREQ(NREQ), .BIN_W(BIN_W), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .bin_in      (bin_in),
    .done_out    (done_out),
    .dig_out     (dig_out),
    .busy        (busy),
    .owner       (owner),
    .timeout_err (timeout_err),
    .conv_start  (conv_start),
    .conv_bin    (conv_bin),
    .conv_ready  (conv_ready),
    .conv_done   (conv_done),
    .conv_dig    (conv_dig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got,
                     input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] to_bcd(input logic [20:0] b);
    int v;
    logic [23:0] r;
    v = int'(b);
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (conv_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, 48'(conv_start), 48'd1);
  endtask

  task automatic serve(input string tag, input int lat,
                       input logic [1:0] exp_own,
                       input logic [23:0] exp_dig);
    wait_start(tag);
    chk({tag, "_owner"}, 48'(owner), 48'(exp_own));
    repeat (lat) tick();
    conv_done = 1'b1;
    conv_dig  = to_bcd(conv_bin);
    #1;
    chk({tag, "_early"}, 48'(done_out), 48'd0);
    tick();
    conv_done = 1'b0;
    conv_dig  = '0;
    chk({tag, "_done"}, 48'(done_out), 48'(2'b01 << exp_own));
    chk({tag, "_slot"}, 48'(dig_out[exp_own*24 +: 24]), 48'(exp_dig));
    tick();
    chk({tag, "_pulse"}, 48'(done_out), 48'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int bad;
    rst_n      = 1'b0;
    req        = 2'b11;
    bin_in     = '0;
    conv_ready = 1'b1;
    conv_done  = 1'b0;
    conv_dig   = '0;
    tick();
    tick();
    chk("rst_busy",  48'(busy), 48'd0);
    chk("rst_dig",   48'(dig_out), 48'd0);
    chk("rst_start", 48'(conv_start), 48'd0);
    chk("rst_owner", 48'(owner), 48'd0);
    chk("rst_done",  48'(done_out), 48'd0);

    rst_n = 1'b1;
    req   = 2'b01;
    bin_in[0 +: BIN_W] = 21'd832040;
    tick();
    chk("single_lat", 48'(conv_start), 48'd1);
    chk("single_bin", 48'(conv_bin), 48'd832040);
    serve("single", 25, 2'd0, 24'h832040);
    req = 2'b00;

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req   = 2'b11;
    bin_in[0 +: BIN_W]     = 21'd55;
    bin_in[BIN_W +: BIN_W] = 21'd6765;
    serve("rot0", 4, 2'd0, 24'h000055);
    serve("rot1", 4, 2'd1, 24'h006765);
    serve("rot2", 4, 2'd0, 24'h000055);
    serve("rot3", 4, 2'd1, 24'h006765);
    req = 2'b00;
    chk("rot_slot0", 48'(dig_out[23:0]), 48'h000055);

    conv_ready = 1'b0;
    req = 2'b10;
    bin_in[BIN_W +: BIN_W] = 21'd1234;
    tick();
    bad = 0;
    repeat (10) begin
      if (conv_start || timeout_err) bad++;
      tick();
    end
    chk("stall_quiet", 48'(bad), 48'd0);
    chk("stall_busy", 48'(busy), 48'd1);
    conv_ready = 1'b1;
    #1;
    chk("stall_go", 48'(conv_start), 48'd1);
    serve("stall", 3, 2'd1, 24'h001234);
    req = 2'b00;

    req = 2'b01;
    bin_in[0 +: BIN_W] = 21'd99;
    tick();
    wait_start("wd");
    tick();
    bad = 0;
    repeat (63) begin
      if (timeout_err || done_out != 2'b00) bad++;
      tick();
    end
    chk("wd_quiet", 48'(bad), 48'd0);
    chk("wd_err", 48'(timeout_err), 48'd1);
    chk("wd_early", 48'(done_out), 48'd0);
    req = 2'b00;
    tick();
    chk("wd_done", 48'(done_out), 48'b01);
    chk("wd_sat", 48'(dig_out[23:0]), 48'h999999);
    chk("wd_errpulse", 48'(timeout_err), 48'd0);
    chk("wd_other", 48'(dig_out[47:24]), 48'h001234);
    tick();
    req = 2'b01;
    bin_in[0 +: BIN_W] = 21'd42;
    serve("wd_next", 5, 2'd0, 24'h000042);
    req = 2'b00;

    req = 2'b10;
    bin_in[BIN_W +: BIN_W] = 21'd777;
    tick();
    wait_start("mid");
    tick();
    tick();
    rst_n = 1'b0;
    req   = 2'b00;
    tick();
    rst_n = 1'b1;
    chk("mid_busy", 48'(busy), 48'd0);
    chk("mid_done", 48'(done_out), 48'd0);
    chk("mid_dig", 48'(dig_out), 48'd0);
    chk("mid_owner", 48'(owner), 48'd0);
    conv_done = 1'b1;
    conv_dig  = 24'h000777;
    tick();
    conv_done = 1'b0;
    conv_dig  = '0;
    chk("late_done", 48'(done_out), 48'd0);
    chk("late_dig", 48'(dig_out), 48'd0);
    chk("late_busy", 48'(busy), 48'd0);
    tick();
    chk("late_done2", 48'(done_out), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
